// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one half-precision adder between NUM_REQ requesters.
// One operation in flight: grant in IDLE, wait ADDER_LATENCY in BUSY, hold the response in RESP.
module fp_add_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int ADDER_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_final,
  output logic [15:0]            add_operand_a,
  output logic [15:0]            add_operand_b,
  output logic                   add_final_operation,
  output logic                   add_reset,
  input  logic [15:0]            add_result,
  input  logic [4:0]             add_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_result,
  output logic [4:0]             rsp_flags
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] winner_s;
  logic [ID_W-1:0] rr_idx_s;
  logic            found_s;
  logic            grant_s;
  logic            capture_s;
  logic [15:0]     sel_a_s, sel_b_s;
  logic            sel_f_s;
  logic [15:0]     op_a_q, op_b_q;
  logic            op_f_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     rsp_result_q;
  logic [4:0]      rsp_flags_q;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    winner_s = last_grant_q;
    found_s  = 1'b0;
    rr_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx_s = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found_s && req_valid[rr_idx_s]) begin
        winner_s = rr_idx_s;
        found_s  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a_s = 16'h0000;
    sel_b_s = 16'h0000;
    sel_f_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_s == ID_W'(i)) begin
        sel_a_s = req_a[16*i +: 16];
        sel_b_s = req_b[16*i +: 16];
        sel_f_s = req_final[i];
      end
    end
  end

  assign grant_s   = (state_q == IDLE) && found_s && !reset;
  assign capture_s = (state_q == BUSY) && (cnt_q <= 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = BUSY;
          cnt_d   = 4'(ADDER_LATENCY);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        if (capture_s) begin
          state_d = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    rsp_valid = (state_q == RESP);
  end

  // Operands stay at the adder until the next grant; results are latched on capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_a_q       <= 16'h0000;
      op_b_q       <= 16'h0000;
      op_f_q       <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 16'h0000;
      rsp_flags_q  <= 5'b00000;
    end else begin
      if (grant_s) begin
        last_grant_q <= winner_s;
        op_a_q       <= sel_a_s;
        op_b_q       <= sel_b_s;
        op_f_q       <= sel_f_s;
      end
      if (capture_s) begin
        rsp_id_q     <= last_grant_q;
        rsp_result_q <= add_result;
        rsp_flags_q  <= add_flags;
      end
    end
  end

  assign add_operand_a       = op_a_q;
  assign add_operand_b       = op_b_q;
  assign add_final_operation = op_f_q;
  assign add_reset           = reset;
  assign rsp_id              = rsp_id_q;
  assign rsp_result          = rsp_result_q;
  assign rsp_flags           = rsp_flags_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: latency-2 adder stand-in, transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fp_add_arbiter;
  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_final;
  logic [16*N-1:0] req_a, req_b;
  logic [15:0]     add_operand_a, add_operand_b, add_result;
  logic            add_final_operation, add_reset;
  logic [4:0]      add_flags;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_result;
  logic [4:0]      rsp_flags;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fp_add_arbiter #(.NUM_REQ(N), .ID_W(2), .ADDER_LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_final(req_final),
    .add_operand_a(add_operand_a), .add_operand_b(add_operand_b),
    .add_final_operation(add_final_operation), .add_reset(add_reset),
    .add_result(add_result), .add_flags(add_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // Adder stand-in: {flags, result}, valid one register stage after the operands settle.
  function automatic logic [20:0] adder_fn(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h7E00) return {5'b10000, 16'h7E00};
    else if (a == 16'h4000 && b == 16'h3C00) return {5'b00000, 16'h4200};
    else return {a[4:0], a ^ {b[7:0], b[15:8]}};
  endfunction

  logic [20:0] adder_q;
  always @(posedge clock) adder_q <= adder_fn(add_operand_a, add_operand_b);
  assign add_result = adder_q[15:0];
  assign add_flags  = adder_q[20:16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one op in flight, response due 3 cycles after grant.
  bit          m_busy = 1'b0;
  int          m_last = N - 1;
  int          m_gcyc = 0;
  int          m_id = 0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0;
  logic        m_f = 1'b0;
  logic [20:0] m_res = 21'h0;
  bit          zero_chk = 1'b0;

  always @(negedge clock) begin
    int          win;
    int          idx;
    logic [N-1:0] exp_ready;
    bit          exp_rv;
    if (reset) begin
      chk("add_reset_hi", {31'd0, add_reset}, 32'd1);
      m_busy = 1'b0; m_last = N - 1;
      m_a = 16'h0; m_b = 16'h0; m_f = 1'b0;
      zero_chk = 1'b1;
    end else begin
      win = -1;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_rv = m_busy && (cyc - m_gcyc >= 3);
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      if (exp_rv) begin
        chk("rsp_id", {30'd0, rsp_id}, m_id);
        chk("rsp_result", {16'd0, rsp_result}, {16'd0, m_res[15:0]});
        chk("rsp_flags", {27'd0, rsp_flags}, {27'd0, m_res[20:16]});
      end
      if (zero_chk) begin
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        chk("rst_rsp_flags", {27'd0, rsp_flags}, 32'd0);
        zero_chk = 1'b0;
      end
      chk("add_operand_a", {16'd0, add_operand_a}, {16'd0, m_a});
      chk("add_operand_b", {16'd0, add_operand_b}, {16'd0, m_b});
      chk("add_final", {31'd0, add_final_operation}, {31'd0, m_f});
      chk("add_reset_lo", {31'd0, add_reset}, 32'd0);
      if (exp_rv && rsp_ready) m_busy = 1'b0;
      if (win >= 0) begin
        m_busy = 1'b1; m_gcyc = cyc; m_last = win; m_id = win;
        m_a = req_a[16*win +: 16]; m_b = req_b[16*win +: 16]; m_f = req_final[win];
        m_res = adder_fn(m_a, m_b);
      end
    end
  end

  // Logs of handshakes actually seen on the DUT ports.
  int          g_id[$];
  int          g_cyc[$];
  int          r_id[$];
  logic [15:0] r_res[$];
  logic [4:0]  r_flg[$];

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          g_id.push_back(i); g_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        r_id.push_back(int'(rsp_id)); r_res.push_back(rsp_result); r_flg.push_back(rsp_flags);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete(); r_id.delete(); r_res.delete(); r_flg.delete();
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic f);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_final[i] = f;
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    while (g_id.size() < n && t < 60) begin tick(); t++; end
    chk("grant_wait", {31'd0, g_id.size() >= n}, 32'd1);
  endtask

  task automatic wait_rsps(input int n);
    int t = 0;
    while (r_id.size() < n && t < 60) begin tick(); t++; end
    chk("rsp_wait", {31'd0, r_id.size() >= n}, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [20:0] e;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_final = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("t0_req_ready", {28'd0, req_ready}, 32'd0);
    chk("t0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t0_op_a", {16'd0, add_operand_a}, 32'd0);
    chk("t0_op_b", {16'd0, add_operand_b}, 32'd0);
    chk("t0_final", {31'd0, add_final_operation}, 32'd0);

    // Single operation, latency and result
    clear_logs();
    set_req(0, 16'h4000, 16'h3C00, 1'b0);
    req_valid = 4'b0001;
    wait_grants(1);
    req_valid = '0;
    chk("t1_grant_id", g_id[0], 32'd0);
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("t1_latency", n, 32'd3);
    chk("t1_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("t1_rsp_result", {16'd0, rsp_result}, 32'h4200);
    chk("t1_rsp_flags", {27'd0, rsp_flags}, 32'd0);
    wait_rsps(1);

    // All four requesters held valid: 0,1,2,3,0 at 4-cycle spacing
    pulse_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, 16'h1000 + 16'(i * 16'h0111), 16'h2000 + 16'(i), 1'b0);
    req_valid = 4'b1111;
    wait_grants(5);
    req_valid = '0;
    wait_rsps(5);
    for (int k = 0; k < 5; k++) chk("t2_order", g_id[k], k % N);
    for (int k = 1; k < 5; k++) chk("t2_interval", g_cyc[k] - g_cyc[k-1], 32'd4);

    // Wrap-around: last grant 1, requesters 1 and 3 valid -> 3 then 1
    clear_logs();
    req_valid = 4'b0010;
    wait_grants(1);
    req_valid = '0;
    chk("t3_setup_grant", g_id[0], 32'd1);
    wait_rsps(1);
    clear_logs();
    req_valid = 4'b1010;
    wait_grants(2);
    req_valid = '0;
    wait_rsps(2);
    chk("t3_first", g_id[0], 32'd3);
    chk("t3_second", g_id[1], 32'd1);

    // Response stall for 10 cycles with another requester waiting
    clear_logs();
    rsp_ready = 1'b0;
    set_req(2, 16'h5A5A, 16'h0F0F, 1'b0);
    e = adder_fn(16'h5A5A, 16'h0F0F);
    req_valid = 4'b0100;
    wait_grants(1);
    req_valid = 4'b0001;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4_hold_ready", {28'd0, req_ready}, 32'd0);
      chk("t4_hold_id", {30'd0, rsp_id}, 32'd2);
      chk("t4_hold_result", {16'd0, rsp_result}, {16'd0, e[15:0]});
      chk("t4_hold_flags", {27'd0, rsp_flags}, {27'd0, e[20:16]});
    end
    chk("t4_no_early_rsp", r_id.size(), 32'd0);
    rsp_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_one_rsp", r_id.size(), 32'd1);
    wait_grants(2);
    req_valid = '0;
    chk("t4_next_grant", g_id[1], 32'd0);
    wait_rsps(2);

    // NaN passthrough with final_operation set
    clear_logs();
    set_req(3, 16'h7E00, 16'h3C00, 1'b1);
    req_valid = 4'b1000;
    wait_grants(1);
    req_valid = '0;
    chk("t5_final_busy", {31'd0, add_final_operation}, 32'd1);
    chk("t5_op_a_busy", {16'd0, add_operand_a}, 32'h7E00);
    wait_rsps(1);
    chk("t5_rsp_id", r_id[0], 32'd3);
    chk("t5_rsp_result", {16'd0, r_res[0]}, 32'h7E00);
    chk("t5_rsp_flags", {27'd0, r_flg[0]}, 32'h10);
    req_final = '0;

    // Reset during BUSY drops the operation
    clear_logs();
    set_req(2, 16'h1111, 16'h2222, 1'b0);
    req_valid = 4'b0100;
    wait_grants(1);
    req_valid = '0;
    pulse_reset();
    chk("t6_req_ready", {28'd0, req_ready}, 32'd0);
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_op_a", {16'd0, add_operand_a}, 32'd0);
    chk("t6_op_b", {16'd0, add_operand_b}, 32'd0);
    chk("t6_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("t6_rsp_result", {16'd0, rsp_result}, 32'd0);
    chk("t6_rsp_flags", {27'd0, rsp_flags}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("t6_rsp_count", r_id.size(), 32'd0);
    clear_logs();
    set_req(0, 16'h0101, 16'h0202, 1'b0);
    req_valid = 4'b0101;
    wait_grants(1);
    req_valid = '0;
    chk("t6_next_grant", g_id[0], 32'd0);
    wait_rsps(1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter that shares one half-precision adder (`fp_adder_16_bit`) between `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the adder's operands and `final_operation`. After a fixed adder latency it captures the 16-bit result and the five status flags, then returns them with the requester ID over a valid/ready response channel. It sits between the requesting engines and the single shared adder instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; range 2..8.
- `ID_W`, default 2: requester ID width; equals clog2(`NUM_REQ`).
- `ADDER_LATENCY`, default 2: cycles from operands being stable at the adder inputs to a valid adder result; range 1..15.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer happens when `req_valid[i] & req_ready[i]`.
- `req_a` in 16*`NUM_REQ`: operand A per requester; requester i uses bits [16i+15:16i].
- `req_b` in 16*`NUM_REQ`: operand B per requester, same packing as `req_a`.
- `req_final` in `NUM_REQ`: `final_operation` bit per requester.
- `add_operand_a` out 16: adder operand A.
- `add_operand_b` out 16: adder operand B.
- `add_final_operation` out 1: adder `final_operation`.
- `add_reset` out 1: adder reset; equals `reset` combinationally.
- `add_result` in 16: adder result.
- `add_flags` in 5: {NaN, infinity, zero, underflow, overflow} from the adder.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: ID of the requester that owns the response.
- `rsp_result` out 16: captured adder result.
- `rsp_flags` out 5: captured flags, same bit order as `add_flags`.

## Operation
- FSM states: IDLE, BUSY, RESP. Only one operation is in flight at a time.
- IDLE:
  - If any `req_valid` bit is set, pick a winner by round-robin, searching from `last_grant+1` upward with wrap-around.
  - Assert `req_ready[winner]` combinationally in the same cycle. No other `req_ready` bit is set.
  - On that edge, register the winner's operands and final bit into `add_*`, set `last_grant` to the winner, load `cnt = ADDER_LATENCY`, and go to BUSY.
- `req_ready` is 0 in BUSY and RESP. A requester must hold `req_valid` and its data stable until granted. `req_ready` never depends on `rsp_ready`.
- BUSY:
  - Hold the `add_*` outputs stable and decrement `cnt` every cycle.
  - On the cycle where `cnt == 1`, capture `add_result` and `add_flags` into `rsp_result` and `rsp_flags`, set `rsp_id` to the winner, and go to RESP.
- RESP:
  - `rsp_valid = 1`; `rsp_id`, `rsp_result` and `rsp_flags` stay stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`, clear `rsp_valid` and go to IDLE.
  - A new grant is possible in the following IDLE cycle, never in the same cycle as the response handshake.
- The `add_*` operands keep their last value in IDLE and RESP; they are not cleared.
- Flags are passed through unmodified. NaN, infinity and similar cases are never interpreted by the arbiter.
- Fairness: a requester that holds `req_valid` is granted within `NUM_REQ` grants.
- Reset:
  - All outputs go to 0: `req_ready`, `add_operand_a`, `add_operand_b`, `add_final_operation`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags`.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority. `cnt = 0`. State = IDLE.
- Reset mid-operation (BUSY or RESP): the in-flight operation is dropped and no response is produced. `add_reset` resets the adder in the same cycle.

## Timing
- The grant handshake takes cycle T, in IDLE. New operands are at the adder from T+1.
- The result is captured at the end of cycle T+`ADDER_LATENCY`. `rsp_valid` rises in cycle T+`ADDER_LATENCY`+1.
- With `rsp_ready` held at 1, the minimum issue interval is `ADDER_LATENCY`+2 cycles. With `ADDER_LATENCY=2`, that is one operation per 4 cycles.
- `rsp_ready` low stalls in RESP indefinitely, with no data loss.
- `req_valid` asserted in the cycle reset deasserts is eligible for a grant in the first IDLE cycle after reset.

## Test plan
- Reset, then check every output is 0 and `req_ready` is 0. Then requester 0 sends A=0x4000, B=0x3C00 with an adder model of latency 2 returning 0x4200. Expect `rsp_valid` 3 cycles after the grant, with `rsp_id`=0, `rsp_result`=0x4200, `rsp_flags`=0.
- All 4 requesters hold `req_valid` continuously. Grants must go 0,1,2,3,0 with each `req_ready` exactly one cycle wide, and 4 cycles between grants when `rsp_ready`=1.
- Requesters 1 and 3 are valid and the last grant was 1. Expect grant 3, then 1 (wrap-around).
- Hold `rsp_ready`=0 for 10 cycles in RESP. The response data must stay stable, `req_ready` must stay 0, and exactly one response is accepted when `rsp_ready` rises.
- The adder returns result 0x7E00 with NaN flag (`add_flags`=5'b10000) and `req_final`=1. Check `add_final_operation`=1 during BUSY and `rsp_flags`=5'b10000 passed through.
- Assert `reset` for one cycle during BUSY. No `rsp_valid` may follow, all outputs must be 0 in the next cycle, and the next grant goes to requester 0.
